// File: rtl/rename_unit.sv
// Register-rename stage between decode and dispatch.
// Renames RENAME_WIDTH instructions per cycle through a speculative RAT and a
// circular free list, bypasses dependencies inside the group, returns old
// mappings to the free list at retire and rolls the speculative RAT back to
// the committed RAT on flush. Outputs are registered (one-cycle latency).
module rename_unit #(
  parameter int  RENAME_WIDTH = 2,
  parameter int  RETIRE_WIDTH = 2,
  parameter int  NUM_AREGS    = 32,
  parameter int  NUM_PREGS    = 64,
  localparam int PW           = $clog2(NUM_PREGS),
  localparam int FL_DEPTH     = NUM_PREGS - NUM_AREGS,
  localparam int FCW          = $clog2(FL_DEPTH + 1),
  localparam int AW           = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RENAME_WIDTH*AW-1:0]   in_rs1,
  input  logic [RENAME_WIDTH*AW-1:0]   in_rs2,
  input  logic [RENAME_WIDTH*AW-1:0]   in_rd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RENAME_WIDTH*PW-1:0]   out_ps1,
  output logic [RENAME_WIDTH*PW-1:0]   out_ps2,
  output logic [RENAME_WIDTH*PW-1:0]   out_pd,
  output logic [RENAME_WIDTH*PW-1:0]   out_old_pd,
  input  logic [RETIRE_WIDTH-1:0]      ret_valid,
  input  logic [RETIRE_WIDTH*AW-1:0]   ret_rd,
  input  logic [RETIRE_WIDTH*PW-1:0]   ret_pd,
  input  logic [RETIRE_WIDTH*PW-1:0]   ret_old_pd,
  input  logic                         flush,
  output logic [FCW-1:0]               free_count
);

  localparam int PTRW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  // Mapping tables and the free-list ring.
  logic [PW-1:0]   spec_rat [NUM_AREGS];
  logic [PW-1:0]   cmt_rat  [NUM_AREGS];
  logic [PW-1:0]   fl_mem   [FL_DEPTH];

  // head: next free entry to allocate. tail/commit_head advance together on
  // retire, so [commit_head, tail) always covers the whole ring; entries
  // [commit_head, head) are speculative allocations, [head, tail) are free.
  logic [PTRW-1:0] head;
  logic [PTRW-1:0] tail;
  logic [PTRW-1:0] commit_head;

  // Combinational rename results for the group on the inputs.
  logic [FCW-1:0]  alloc_cnt;
  logic [PW-1:0]   ps1_c [RENAME_WIDTH];
  logic [PW-1:0]   ps2_c [RENAME_WIDTH];
  logic [PW-1:0]   pd_c  [RENAME_WIDTH];
  logic [PW-1:0]   old_c [RENAME_WIDTH];

  // Compressed retire slots (ret_rd==0 slots take no ring entry).
  logic [FCW-1:0]  ret_cnt;
  logic            ret_do  [RETIRE_WIDTH];
  logic [PTRW-1:0] ret_idx [RETIRE_WIDTH];

  logic            fire;

  // Ring pointer advance modulo FL_DEPTH (depth need not be a power of two).
  function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] ptr,
                                               input logic [FCW-1:0]  inc);
    int sum;
    sum = int'(ptr) + int'(inc);
    if (sum >= FL_DEPTH) sum = sum - FL_DEPTH;
    return PTRW'(sum);
  endfunction

  // Rename lookup: RAT read, allocation from the ring, intra-group bypass.
  always_comb begin
    alloc_cnt = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      ps1_c[k] = '0;
      ps2_c[k] = '0;
      pd_c[k]  = '0;
      old_c[k] = '0;
    end
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (in_rs1[k*AW +: AW] != '0) ps1_c[k] = spec_rat[in_rs1[k*AW +: AW]];
      if (in_rs2[k*AW +: AW] != '0) ps2_c[k] = spec_rat[in_rs2[k*AW +: AW]];
      if (in_rd[k*AW +: AW]  != '0) old_c[k] = spec_rat[in_rd[k*AW +: AW]];
      // Ascending j: the youngest older writer is applied last and wins.
      for (int j = 0; j < k; j++) begin
        if (in_rd[j*AW +: AW] != '0) begin
          if (in_rd[j*AW +: AW] == in_rs1[k*AW +: AW]) ps1_c[k] = pd_c[j];
          if (in_rd[j*AW +: AW] == in_rs2[k*AW +: AW]) ps2_c[k] = pd_c[j];
          if (in_rd[j*AW +: AW] == in_rd[k*AW +: AW])  old_c[k] = pd_c[j];
        end
      end
      if (in_rd[k*AW +: AW] != '0) begin
        pd_c[k] = fl_mem[wrap_add(head, alloc_cnt)];
        // NOTE: alloc_cnt is a running rank inside this combinational loop,
        // so it is updated with a blocking assignment and read back later in
        // the same pass; state elements below use non-blocking only.
        alloc_cnt = alloc_cnt + FCW'(1);
      end
    end
  end

  // Retire compaction: ring slot for each retiring instruction with a dest.
  always_comb begin
    ret_cnt = '0;
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      ret_do[r]  = ret_valid[r] && (ret_rd[r*AW +: AW] != '0);
      ret_idx[r] = wrap_add(tail, ret_cnt);
      if (ret_do[r]) ret_cnt = ret_cnt + FCW'(1);
    end
  end

  // All-or-nothing acceptance: every dest in the group must get a register.
  assign in_ready = !flush && (!out_valid || out_ready) && (free_count >= alloc_cnt);
  assign fire     = in_valid && in_ready;

  // Speculative and committed RAT updates; flush restores post-retire state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        spec_rat[i] <= PW'(i);
        cmt_rat[i]  <= PW'(i);
      end
    end else begin
      // NOTE: several non-blocking writes to the same RAT entry in one block
      // resolve to the last one scheduled, which gives slot-order priority
      // (youngest wins) for both WAW renames and same-rd retires.
      for (int r = 0; r < RETIRE_WIDTH; r++)
        if (ret_do[r]) cmt_rat[ret_rd[r*AW +: AW]] <= ret_pd[r*PW +: PW];
      if (flush) begin
        for (int i = 0; i < NUM_AREGS; i++) spec_rat[i] <= cmt_rat[i];
        for (int r = 0; r < RETIRE_WIDTH; r++)
          if (ret_do[r]) spec_rat[ret_rd[r*AW +: AW]] <= ret_pd[r*PW +: PW];
      end else if (fire) begin
        for (int k = 0; k < RENAME_WIDTH; k++)
          if (in_rd[k*AW +: AW] != '0) spec_rat[in_rd[k*AW +: AW]] <= pd_c[k];
      end
    end
  end

  // Free-list ring: retired old mappings are pushed at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the ring contents are architectural (they define which pregs
      // are free after reset), so this memory is reset explicitly.
      for (int i = 0; i < FL_DEPTH; i++) fl_mem[i] <= PW'(NUM_AREGS + i);
    end else begin
      for (int r = 0; r < RETIRE_WIDTH; r++)
        if (ret_do[r]) fl_mem[ret_idx[r]] <= ret_old_pd[r*PW +: PW];
    end
  end

  // Ring pointers and free count; registers freed this cycle count next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      commit_head <= '0;
      free_count  <= FCW'(FL_DEPTH);
    end else begin
      tail        <= wrap_add(tail, ret_cnt);
      commit_head <= wrap_add(commit_head, ret_cnt);
      if (flush) begin
        head       <= wrap_add(commit_head, ret_cnt);
        free_count <= FCW'(FL_DEPTH);
      end else if (fire) begin
        head       <= wrap_add(head, alloc_cnt);
        free_count <= free_count + ret_cnt - alloc_cnt;
      end else begin
        free_count <= free_count + ret_cnt;
      end
    end
  end

  // Registered output group; held stable while dispatch back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ps1    <= '0;
      out_ps2    <= '0;
      out_pd     <= '0;
      out_old_pd <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        out_ps1[k*PW +: PW]    <= ps1_c[k];
        out_ps2[k*PW +: PW]    <= ps2_c[k];
        out_pd[k*PW +: PW]     <= pd_c[k];
        out_old_pd[k*PW +: PW] <= old_c[k];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed scenarios with literal
// expectations plus a randomized rename/dispatch/retire/flush run, all
// compared every cycle against a queue-based rename model.
module tb_rename_unit;

  localparam int RW  = 2;
  localparam int TW  = 2;
  localparam int NA  = 32;
  localparam int NP  = 64;
  localparam int PW  = 6;
  localparam int FL  = NP - NA;
  localparam int FCW = 6;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [RW*AW-1:0]  in_rs1, in_rs2, in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [RW*PW-1:0]  out_ps1, out_ps2, out_pd, out_old_pd;
  logic [TW-1:0]     ret_valid;
  logic [TW*AW-1:0]  ret_rd;
  logic [TW*PW-1:0]  ret_pd, ret_old_pd;
  logic              flush;
  logic [FCW-1:0]    free_count;

  rename_unit #(
    .RENAME_WIDTH(RW), .RETIRE_WIDTH(TW), .NUM_AREGS(NA), .NUM_PREGS(NP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_pd(ret_pd), .ret_old_pd(ret_old_pd),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  // ---------------- reference model ----------------
  typedef struct { int rd; int pd; int old_pd; } rob_t;

  int   m_spec [NA];
  int   m_cmt  [NA];
  int   m_fq [$];        // free registers, allocation order
  int   m_alloc_q [$];   // allocated, not yet retired, allocation order
  rob_t rob [$];         // dispatched, not yet retired
  bit   m_valid;
  int   m_ps1 [RW], m_ps2 [RW], m_pd [RW], m_old [RW], m_rd [RW];
  int   cmp_dup;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_p(input logic [63:0] v, input int k);
    return int'(v[k*PW +: PW]);
  endfunction

  function automatic int get_a(input logic [63:0] v, input int k);
    return int'(v[k*AW +: AW]);
  endfunction

  function automatic int n_dest();
    int n = 0;
    for (int k = 0; k < RW; k++) if (get_a(in_rd, k) != 0) n++;
    return n;
  endfunction

  function automatic bit exp_ready();
    return !flush && (!m_valid || out_ready) && (m_fq.size() >= n_dest());
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_spec[i] = i;
      m_cmt[i]  = i;
    end
    m_fq.delete();
    for (int i = 0; i < FL; i++) m_fq.push_back(NA + i);
    m_alloc_q.delete();
    rob.delete();
    m_valid = 1'b0;
    for (int k = 0; k < RW; k++) begin
      m_ps1[k] = 0; m_ps2[k] = 0; m_pd[k] = 0; m_old[k] = 0; m_rd[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit fire;
    int rs1, rs2, rd, p;
    if (rst) begin
      model_reset();
      return;
    end
    fire = in_valid && exp_ready();
    if (m_valid && out_ready)
      for (int k = 0; k < RW; k++)
        rob.push_back('{rd: m_rd[k], pd: m_pd[k], old_pd: m_old[k]});
    for (int r = 0; r < TW; r++) begin
      rd = get_a(ret_rd, r);
      if (ret_valid[r] && rd != 0) begin
        m_cmt[rd] = get_p(ret_pd, r);
        m_fq.push_back(get_p(ret_old_pd, r));
        p = m_alloc_q.pop_front();
      end
    end
    if (flush) begin
      m_spec    = m_cmt;
      m_fq      = {m_alloc_q, m_fq};
      m_alloc_q.delete();
      rob.delete();
      m_valid   = 1'b0;
    end else if (fire) begin
      // Slots renamed one after another: later slots see earlier renames.
      for (int k = 0; k < RW; k++) begin
        rs1 = get_a(in_rs1, k);
        rs2 = get_a(in_rs2, k);
        rd  = get_a(in_rd, k);
        m_ps1[k] = (rs1 == 0) ? 0 : m_spec[rs1];
        m_ps2[k] = (rs2 == 0) ? 0 : m_spec[rs2];
        m_rd[k]  = rd;
        if (rd != 0) begin
          m_old[k]  = m_spec[rd];
          m_pd[k]   = m_fq.pop_front();
          m_spec[rd] = m_pd[k];
          m_alloc_q.push_back(m_pd[k]);
        end else begin
          m_old[k] = 0;
          m_pd[k]  = 0;
        end
      end
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", out_valid, m_valid);
      check("free_count", free_count, m_fq.size());
      check("free_plus_live", free_count + m_alloc_q.size(), FL);
      check("in_ready", in_ready, exp_ready());
      if (m_valid) begin
        for (int k = 0; k < RW; k++) begin
          check($sformatf("out_ps1[%0d]", k), get_p(out_ps1, k), m_ps1[k]);
          check($sformatf("out_ps2[%0d]", k), get_p(out_ps2, k), m_ps2[k]);
          check($sformatf("out_pd[%0d]", k), get_p(out_pd, k), m_pd[k]);
          check($sformatf("out_old_pd[%0d]", k), get_p(out_old_pd, k), m_old[k]);
          if (m_pd[k] != 0) begin
            cmp_dup = 0;
            for (int a = 0; a < NA; a++) if (m_cmt[a] == get_p(out_pd, k)) cmp_dup++;
            check("pd_not_committed", cmp_dup, 0);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_rd      = '0;
    out_ready  = 1'b1;
    ret_valid  = '0;
    ret_rd     = '0;
    ret_pd     = '0;
    ret_old_pd = '0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    started = 1'b1;
  endtask

  task automatic set_group(input int rd0, input int rd1, input int a0, input int a1,
                           input int b0, input int b1);
    in_valid = 1'b1;
    in_rd    = {AW'(rd1), AW'(rd0)};
    in_rs1   = {AW'(a1), AW'(a0)};
    in_rs2   = {AW'(b1), AW'(b0)};
  endtask

  task automatic drive_retire(input int cnt);
    rob_t e;
    ret_valid  = '0;
    ret_rd     = '0;
    ret_pd     = '0;
    ret_old_pd = '0;
    for (int r = 0; r < TW; r++) begin
      if (r < cnt && rob.size() > 0) begin
        e = rob.pop_front();
        ret_valid[r]            = 1'b1;
        ret_rd[r*AW +: AW]      = AW'(e.rd);
        ret_pd[r*PW +: PW]      = PW'(e.pd);
        ret_old_pd[r*PW +: PW]  = PW'(e.old_pd);
      end
    end
  endtask

  task automatic check_pair(input string name, input logic [RW*PW-1:0] v, input int e0, input int e1);
    check({name, "[0]"}, get_p(v, 0), e0);
    check({name, "[1]"}, get_p(v, 1), e1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rc;
    rst = 1'b1;
    idle();
    do_reset();

    // Reset state
    check("reset_out_valid", out_valid, 0);
    check("reset_free_count", free_count, 32);
    check("reset_out_pd", out_pd, 0);
    check("reset_out_ps1", out_ps1, 0);

    // Basic allocation and intra-group source bypass
    set_group(5, 6, 0, 5, 0, 0);
    #1 check("t1_in_ready", in_ready, 1);
    tick();
    check_pair("t1_pd", out_pd, 32, 33);
    check_pair("t1_ps1", out_ps1, 0, 32);
    check_pair("t1_old_pd", out_old_pd, 5, 6);
    check("t1_free_count", free_count, 30);
    idle();
    tick();

    // WAW inside a group, then a later read of the youngest mapping
    do_reset();
    set_group(7, 7, 0, 0, 7, 7);
    tick();
    check_pair("t2_ps2", out_ps2, 7, 32);
    check_pair("t2_pd", out_pd, 32, 33);
    check_pair("t2_old_pd", out_old_pd, 7, 32);
    set_group(0, 0, 7, 0, 0, 0);
    tick();
    check("t2_rat_youngest", get_p(out_ps1, 0), 33);
    idle();
    tick();

    // Free-list exhaustion, retire-then-accept, ring wrap
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_group(2*i + 1, 2*i + 2, 0, 0, 0, 0);
      tick();
    end
    set_group(31, 0, 0, 0, 0, 0);
    tick();
    check("t3_free_count_1", free_count, 1);
    set_group(4, 5, 0, 0, 0, 0);
    #1 check("t3_blocked", in_ready, 0);
    tick();
    check("t3_no_change", free_count, 1);
    drive_retire(1);
    #1 check("t3_blocked_during_retire", in_ready, 0);
    tick();
    check("t3_free_after_retire", free_count, 2);
    ret_valid = '0;
    #1 check("t3_unblocked", in_ready, 1);
    tick();
    check_pair("t3_wrap_pd", out_pd, 63, 1);
    check("t3_free_zero", free_count, 0);
    idle();
    tick();

    // Retire plus flush in the same cycle restores the committed view
    do_reset();
    set_group(5, 6, 0, 0, 0, 0);
    tick();
    set_group(7, 8, 0, 0, 0, 0);
    tick();
    idle();
    drive_retire(2);
    flush = 1'b1;
    #1 check("t4_flush_blocks", in_ready, 0);
    tick();
    check("t4_free_count", free_count, 32);
    check("t4_out_valid", out_valid, 0);
    idle();
    set_group(0, 9, 5, 7, 6, 8);
    tick();
    check_pair("t4_ps1", out_ps1, 32, 7);
    check_pair("t4_ps2", out_ps2, 33, 8);
    check_pair("t4_pd", out_pd, 0, 34);
    check_pair("t4_old_pd", out_old_pd, 0, 9);
    idle();
    tick();

    // Back-pressure: outputs hold, input stalls
    do_reset();
    set_group(1, 2, 0, 0, 0, 0);
    out_ready = 1'b0;
    tick();
    check("t5_valid", out_valid, 1);
    set_group(3, 4, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1 check("t5_stall", in_ready, 0);
      tick();
      check("t5_hold_valid", out_valid, 1);
      check_pair("t5_hold_pd", out_pd, 32, 33);
    end
    out_ready = 1'b1;
    #1 check("t5_release", in_ready, 1);
    tick();
    check_pair("t5_next_pd", out_pd, 34, 35);
    idle();
    tick();

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < RW; k++) begin
        in_rd[k*AW +: AW]  = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, 31));
        in_rs1[k*AW +: AW] = AW'($urandom_range(0, 31));
        in_rs2[k*AW +: AW] = AW'($urandom_range(0, 31));
      end
      if (((c / 100) % 2) == 1) rc = $urandom_range(0, 2);
      else                      rc = ($urandom_range(0, 3) == 0) ? 1 : 0;
      drive_retire(rc);
      tick();
    end
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
